multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM sequencing the 64-bit RV64I-subset datapath: FETCH, DECODE, EXEC, MEM, WB.

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle RV64I-subset datapath.
// Optional macro ILLEGAL_TRAP_EN: an illegal opcode parks the FSM in TRAP (illegal=1) until reset.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [CNT_W-1:0] instr_count,
  output logic             mem_err,
  output logic             illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif

  state_t state, state_next;

  logic is_r, is_i, is_load, is_store, is_branch, is_legal;
  logic stall, timeout, retire;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

  assign stall  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

  // A MEM instruction aborted by timeout never reaches a retire point.
  assign retire = (state == S_WB)
               || ((state == S_EXEC) && is_branch)
               || ((state == S_MEM) && is_store && mem_ready);

  // Stall counter exists only when a timeout is configured.
  if (WAIT_MAX > 0) begin : g_timeout
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout = stall && (wait_cnt == WAIT_W'(WAIT_MAX));

    always_ff @(posedge clk) begin
      if (!reset) begin
        wait_cnt <= '0;
      end else if (stall && !timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_count <= '0;
      mem_err     <= 1'b0;
    end else begin
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (is_r || is_i)             state_next = S_WB;
        else if (is_load || is_store) state_next = S_MEM;
        else                          state_next = S_FETCH;
      end
      S_MEM:    if (mem_ready) state_next = is_load ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase
    if (timeout) state_next = S_FETCH;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    // Holding reset low silences every control line, even mid-transaction.
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC, S_WB: begin
          // WB keeps the EXEC ALU setup so the result stays stable while written.
          if (is_r) begin
            alu_op = ALU_FUNCT;
          end else if (is_i) begin
            alu_src = 1'b1;
            alu_op  = ALU_FUNCT;
          end else if (is_load || is_store) begin
            alu_src = 1'b1;
          end else if (is_branch && (state == S_EXEC)) begin
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = zero;
          end
          if (state == S_WB) begin
            reg_write  = 1'b1;
            mem_to_reg = is_load;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          alu_src = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed test of multicycle_ctrl with hand-computed per-cycle control vectors.
// Honours ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src;
  logic [1:0]  alu_op;
  logic [31:0] instr_count;
  logic        mem_err;
  logic        illegal;
  logic [9:0]  ctrl;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src, alu_op}
  localparam logic [9:0] C_IDLE       = 10'b0000000000;
  localparam logic [9:0] C_FETCH_RDY  = 10'b1011000000;
  localparam logic [9:0] C_FETCH_WAIT = 10'b1000000000;
  localparam logic [9:0] C_EX_R       = 10'b0000000010;
  localparam logic [9:0] C_EX_I       = 10'b0000000110;
  localparam logic [9:0] C_EX_LS      = 10'b0000000100;
  localparam logic [9:0] C_EX_BR_T    = 10'b0001100001;
  localparam logic [9:0] C_EX_BR_N    = 10'b0000100001;
  localparam logic [9:0] C_MEM_LD     = 10'b1000000100;
  localparam logic [9:0] C_MEM_ST     = 10'b1100000100;
  localparam logic [9:0] C_WB_R       = 10'b0000010010;
  localparam logic [9:0] C_WB_I       = 10'b0000010110;
  localparam logic [9:0] C_WB_LD      = 10'b0000011100;

  assign ctrl = {mem_req, mem_we, ir_write, pc_write, pc_src,
                 reg_write, mem_to_reg, alu_src, alu_op};

  multicycle_ctrl #(.CNT_W(32), .WAIT_MAX(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .instr_count (instr_count),
    .mem_err     (mem_err),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive_cycle(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    drive_cycle(1'b1);
    total++;
    if ({ctrl, illegal} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", {ctrl, illegal}, 11'd0);
    end
    total++;
    if ({instr_count, mem_err} !== 33'd0) begin
      bad++; $display("FAIL reset_state: count=%0d err=%b want 0/0", instr_count, mem_err);
    end
    reset = 1'b1; mem_ready = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_rtype();
    logic [9:0] exp_ctrl [4];
    exp_ctrl = '{C_FETCH_RDY, C_IDLE, C_EX_R, C_WB_R};
    opcode = OP_R; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1);
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL rtype_c%0d: got %b want %b", i + 1, ctrl, exp_ctrl[i]);
      end
    end
    exp_cnt++;
    @(posedge clk); #1;
    total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL rtype_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_load_wait();
    logic [9:0] exp_ctrl [7];
    logic       rdy      [7];
    exp_ctrl = '{C_FETCH_RDY, C_IDLE, C_EX_LS, C_MEM_LD, C_MEM_LD, C_MEM_LD, C_WB_LD};
    rdy      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = OP_LD;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(rdy[i]);
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL load_c%0d: got %b want %b", i + 1, ctrl, exp_ctrl[i]);
      end
    end
    exp_cnt++;
    @(posedge clk); #1;
    total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL load_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_branch();
    logic [9:0] exp_ctrl [3];
    opcode = OP_BR;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      exp_ctrl = '{C_FETCH_RDY, C_IDLE, (z == 1) ? C_EX_BR_T : C_EX_BR_N};
      for (int i = 0; i < 3; i++) begin
        drive_cycle(1'b1);
        total++;
        if (ctrl !== exp_ctrl[i]) begin
          bad++; $display("FAIL branch_z%0d_c%0d: got %b want %b", z, i + 1, ctrl, exp_ctrl[i]);
        end
      end
      exp_cnt++;
      @(posedge clk); #1;
      total++;
      if (instr_count !== exp_cnt) begin
        bad++; $display("FAIL branch_z%0d_count: got %0d want %0d", z, instr_count, exp_cnt);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_ctrl [8];
    logic [6:0] ops      [8];
    exp_ctrl = '{C_FETCH_RDY, C_IDLE, C_EX_I, C_WB_I, C_FETCH_RDY, C_IDLE, C_EX_LS, C_MEM_ST};
    ops      = '{OP_I, OP_I, OP_I, OP_I, OP_ST, OP_ST, OP_ST, OP_ST};
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i];
      drive_cycle(1'b1);
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL b2b_c%0d: got %b want %b", i + 1, ctrl, exp_ctrl[i]);
      end
    end
    exp_cnt = exp_cnt + 32'd2;
    @(posedge clk); #1;
    total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_fetch_timeout();
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b0);
      total++;
      if ({ctrl, mem_err} !== {C_FETCH_WAIT, 1'b0}) begin
        bad++; $display("FAIL ftimeout_stall%0d: got %b want %b", i, {ctrl, mem_err}, {C_FETCH_WAIT, 1'b0});
      end
    end
    @(posedge clk); #1;
    total++;
    if (mem_err !== 1'b1) begin
      bad++; $display("FAIL ftimeout_err: got %b want 1", mem_err);
    end
    drive_cycle(1'b0);
    total++;
    if ({ctrl, mem_err} !== {C_FETCH_WAIT, 1'b1}) begin
      bad++; $display("FAIL ftimeout_after: got %b want %b", {ctrl, mem_err}, {C_FETCH_WAIT, 1'b1});
    end
  endtask

  task automatic test_mem_timeout();
    logic [9:0] exp_ctrl [3];
    exp_ctrl = '{C_FETCH_RDY, C_IDLE, C_EX_LS};
    opcode = OP_LD;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1);
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL mtimeout_c%0d: got %b want %b", i + 1, ctrl, exp_ctrl[i]);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b0);
      if (i == 16) begin
        total++;
        if (ctrl !== C_MEM_LD) begin
          bad++; $display("FAIL mtimeout_stall16: got %b want %b", ctrl, C_MEM_LD);
        end
      end
    end
    drive_cycle(1'b0);
    total++;
    if ({ctrl, mem_err} !== {C_FETCH_WAIT, 1'b1}) begin
      bad++; $display("FAIL mtimeout_abort: got %b want %b", {ctrl, mem_err}, {C_FETCH_WAIT, 1'b1});
    end
    @(posedge clk); #1;
    total++;
    if (instr_count !== exp_cnt) begin
      bad++; $display("FAIL mtimeout_count: got %0d want %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    opcode = OP_BAD;
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    total++;
    if ({ctrl, illegal} !== 11'd0) begin
      bad++; $display("FAIL illegal_decode: got %b want %b", {ctrl, illegal}, 11'd0);
    end
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1);
      total++;
      if ({ctrl, illegal} !== {C_IDLE, 1'b1}) begin
        bad++; $display("FAIL illegal_trap%0d: got %b want %b", i, {ctrl, illegal}, {C_IDLE, 1'b1});
      end
    end
    @(negedge clk);
    reset = 1'b0; #1;
    total++;
    if ({ctrl, illegal} !== 11'd0) begin
      bad++; $display("FAIL illegal_reset: got %b want %b", {ctrl, illegal}, 11'd0);
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; #1;
    exp_cnt = 32'd0;
    total++;
    if ({ctrl, illegal, instr_count} !== {C_FETCH_WAIT, 1'b0, exp_cnt}) begin
      bad++; $display("FAIL illegal_release: got %b/%0d want %b/%0d",
                      {ctrl, illegal}, instr_count, {C_FETCH_WAIT, 1'b0}, exp_cnt);
    end
`else
    drive_cycle(1'b0);
    total++;
    if ({ctrl, illegal, instr_count} !== {C_FETCH_WAIT, 1'b0, exp_cnt}) begin
      bad++; $display("FAIL illegal_nop: got %b/%0d want %b/%0d",
                      {ctrl, illegal}, instr_count, {C_FETCH_WAIT, 1'b0}, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [9:0] exp_ctrl [4];
    logic       rdy      [4];
    exp_ctrl = '{C_FETCH_RDY, C_IDLE, C_EX_LS, C_MEM_ST};
    rdy      = '{1'b1, 1'b0, 1'b0, 1'b0};
    opcode = OP_ST;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(rdy[i]);
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL abort_c%0d: got %b want %b", i + 1, ctrl, exp_ctrl[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0; #1;
    total++;
    if (ctrl !== C_IDLE) begin
      bad++; $display("FAIL abort_in_reset: got %b want %b", ctrl, C_IDLE);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    exp_cnt = 32'd0;
    total++;
    if ({ctrl, mem_err, illegal, instr_count} !== {C_FETCH_WAIT, 1'b0, 1'b0, exp_cnt}) begin
      bad++; $display("FAIL abort_release: got %b/%0d want %b/%0d",
                      {ctrl, mem_err, illegal}, instr_count, {C_FETCH_WAIT, 2'b00}, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_abort();
    test_rtype();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
